demux_1ton_buf: RTL and testbench

DEMUX_1TON_BUF -- requirements
Module: demux_1ton_buf

---
 rtl/demux_1ton_buf.sv | 139 +++++++++++++
 tb/tb_demux_1ton_buf.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_1ton_buf.sv
// demux_1ton_buf
//   Routes one input word stream to NUM_CH independent first-word-fall-through
//   FIFOs, each FIFO_DEPTH entries deep. The selected channel takes a word when
//   valid_in is high and that channel is not full.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   data_in    input word
//   valid_in   push request for data_in
//   selector   destination channel index
//   ready_in   selected channel can accept a word (combinational)
//   data_out   flattened head words, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   valid_out  per-channel head word valid (channel not empty)
//   pop        per-channel head removal request
//   full       per-channel FIFO full
//   ovf_err    sticky per-channel overflow (push attempted while full)
//   sel_err    sticky out-of-range selector on a push request
module demux_1ton_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         valid_in,
  input  logic [SEL_WIDTH-1:0]         selector,
  output logic                         ready_in,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
  output logic [NUM_CH-1:0]            valid_out,
  input  logic [NUM_CH-1:0]            pop,
  output logic [NUM_CH-1:0]            full,
  output logic [NUM_CH-1:0]            ovf_err,
  output logic                         sel_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem_q    [NUM_CH][FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q [NUM_CH];
  logic [PW-1:0]         wr_ptr_d [NUM_CH];
  logic [PW-1:0]         rd_ptr_q [NUM_CH];
  logic [PW-1:0]         rd_ptr_d [NUM_CH];
  logic [CW-1:0]         cnt_q    [NUM_CH];
  logic [CW-1:0]         cnt_d    [NUM_CH];
  logic [NUM_CH-1:0]     ovf_q, ovf_d;
  logic                  sel_err_q, sel_err_d;

  logic [NUM_CH-1:0]     hit;
  logic [NUM_CH-1:0]     full_w;
  logic [NUM_CH-1:0]     empty_w;
  logic [NUM_CH-1:0]     push_ch;
  logic [NUM_CH-1:0]     pop_ch;
  logic                  sel_ok;

  // One-hot decode of the selector; an out-of-range index matches no channel,
  // which keeps every per-channel index below in range.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      hit[i] = (selector == SEL_WIDTH'(i));
    end
  end

  always_comb begin
    full_w  = '0;
    empty_w = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      full_w[i]  = (cnt_q[i] == CW'(FIFO_DEPTH));
      empty_w[i] = (cnt_q[i] == '0);
    end
  end

  // Acceptance looks only at registered fullness, so a pop in the same cycle
  // never opens room for a push to a full channel.
  assign sel_ok   = |hit;
  assign ready_in = |(hit & ~full_w);
  assign push_ch  = {NUM_CH{valid_in}} & hit & ~full_w;
  assign pop_ch   = pop & ~empty_w;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i] + PW'(push_ch[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop_ch[i]);
      cnt_d[i]    = cnt_q[i] + CW'(push_ch[i]) - CW'(pop_ch[i]);
    end
    ovf_d     = ovf_q | ({NUM_CH{valid_in}} & hit & full_w);
    sel_err_d = sel_err_q | (valid_in & ~sel_ok);
  end

  // Storage carries no reset; an empty channel masks its head to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (push_ch[i]) begin
          mem_q[i][wr_ptr_q[i]] <= data_in;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      ovf_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      ovf_q     <= ovf_d;
      sel_err_q <= sel_err_d;
    end
  end

  always_comb begin
    data_out = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!empty_w[i]) begin
        data_out[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i][rd_ptr_q[i]];
      end
    end
  end

  assign valid_out = ~empty_w;
  assign full      = full_w;
  assign ovf_err   = ovf_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_demux_1ton_buf.sv
module tb_demux_1ton_buf;

  localparam int NCH   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        valid_in;
  logic [1:0]  selector;
  logic        ready_in;
  logic [31:0] data_out;
  logic [3:0]  valid_out;
  logic [3:0]  pop;
  logic [3:0]  full;
  logic [3:0]  ovf_err;
  logic        sel_err;

  // Second instance with three channels so selector value 3 is out of range.
  logic        valid_b;
  logic        ready_b;
  logic [23:0] data_out_b;
  logic [2:0]  valid_out_b;
  logic [2:0]  pop_b;
  logic [2:0]  full_b;
  logic [2:0]  ovf_b;
  logic        sel_err_b;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  demux_1ton_buf #(
    .DATA_WIDTH(8), .NUM_CH(NCH), .SEL_WIDTH(2), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .selector(selector), .ready_in(ready_in), .data_out(data_out),
    .valid_out(valid_out), .pop(pop), .full(full), .ovf_err(ovf_err),
    .sel_err(sel_err)
  );

  demux_1ton_buf #(
    .DATA_WIDTH(8), .NUM_CH(3), .SEL_WIDTH(2), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_b),
    .selector(selector), .ready_in(ready_b), .data_out(data_out_b),
    .valid_out(valid_out_b), .pop(pop_b), .full(full_b), .ovf_err(ovf_b),
    .sel_err(sel_err_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per channel holding the words in order.
  logic [7:0] mq [NCH][$];
  logic [3:0] m_ovf = '0;
  logic       m_sel = 1'b0;

  always @(posedge clk) begin
    bit do_push;
    if (!reset) begin
      for (int c = 0; c < NCH; c++) mq[c].delete();
      m_ovf = '0;
      m_sel = 1'b0;
    end else begin
      do_push = 1'b0;
      if (valid_in) begin
        if (int'(selector) >= NCH) m_sel = 1'b1;
        else if (mq[selector].size() >= DEPTH) m_ovf[selector] = 1'b1;
        else do_push = 1'b1;
      end
      for (int c = 0; c < NCH; c++)
        if (pop[c] && mq[c].size() > 0) void'(mq[c].pop_front());
      if (do_push) mq[selector].push_back(data_in);
    end
  end

  always @(negedge clk) begin
    logic [31:0] e_data;
    logic [3:0]  e_valid, e_full;
    logic        e_ready;
    if (chk_en) begin
      e_data = '0; e_valid = '0; e_full = '0;
      for (int c = 0; c < NCH; c++) begin
        if (mq[c].size() > 0) begin
          e_valid[c] = 1'b1;
          e_data[c*8 +: 8] = mq[c][0];
        end
        e_full[c] = (mq[c].size() == DEPTH);
      end
      e_ready = (int'(selector) < NCH) && (mq[selector].size() < DEPTH);
      check("m_valid_out", 64'(valid_out), 64'(e_valid));
      check("m_data_out",  64'(data_out),  64'(e_data));
      check("m_full",      64'(full),      64'(e_full));
      check("m_ovf_err",   64'(ovf_err),   64'(m_ovf));
      check("m_sel_err",   64'(sel_err),   64'(m_sel));
      check("m_ready_in",  64'(ready_in),  64'(e_ready));
    end
  end

  task automatic cyc(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] p);
    valid_in = v; selector = s; data_in = d; pop = p;
    @(posedge clk); #1;
    valid_in = 1'b0; pop = '0;
  endtask

  initial begin
    reset = 1'b0; valid_in = 1'b0; selector = '0; data_in = '0; pop = '0;
    valid_b = 1'b0; pop_b = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;

    check("rst_valid_out", 64'(valid_out), 64'h0);
    check("rst_data_out",  64'(data_out),  64'h0);
    check("rst_full",      64'(full),      64'h0);
    check("rst_ovf",       64'(ovf_err),   64'h0);

    // Single push to channel 2
    cyc(1'b1, 2'd2, 8'hA5, 4'b0000);
    check("p2_valid_out", 64'(valid_out), 64'h4);
    check("p2_data_out",  64'(data_out),  64'h00A5_0000);
    cyc(1'b0, 2'd0, 8'h00, 4'b0100);
    check("p2_drained", 64'(valid_out), 64'h0);

    // Fill channel 0, overflow, then drain in order
    for (int k = 1; k <= 4; k++) cyc(1'b1, 2'd0, 8'(k), 4'b0000);
    check("ch0_full", 64'(full[0]), 64'h1);
    valid_in = 1'b1; selector = 2'd0; data_in = 8'h05; pop = 4'b0001;
    #1;
    check("ch0_ready_full", 64'(ready_in), 64'h0);
    @(posedge clk); #1;
    valid_in = 1'b0; pop = '0;
    check("ch0_ovf", 64'(ovf_err[0]), 64'h1);
    check("ch0_head_after_pop", 64'(data_out[7:0]), 64'h02);
    for (int k = 2; k <= 4; k++) begin
      check("ch0_order", 64'(data_out[7:0]), 64'(k));
      cyc(1'b0, 2'd0, 8'h00, 4'b0001);
    end
    check("ch0_empty", 64'(valid_out[0]), 64'h0);

    // Pop on empty channel and valid_in=0 are no-ops
    cyc(1'b0, 2'd1, 8'hFF, 4'b1111);
    check("noop_valid_out", 64'(valid_out), 64'h0);

    // Simultaneous push and pop on channel 1
    cyc(1'b1, 2'd1, 8'h11, 4'b0000);
    cyc(1'b1, 2'd1, 8'h22, 4'b0010);
    check("ch1_head", 64'(data_out[15:8]), 64'h22);
    cyc(1'b0, 2'd1, 8'h00, 4'b0010);
    check("ch1_count1", 64'(valid_out[1]), 64'h0);

    // Out-of-range selector on the three-channel instance
    selector = 2'd3; data_in = 8'h77; valid_b = 1'b1;
    #1;
    check("b_ready", 64'(ready_b), 64'h0);
    @(posedge clk); #1;
    valid_b = 1'b0;
    check("b_sel_err",   64'(sel_err_b),   64'h1);
    check("b_valid_out", 64'(valid_out_b), 64'h0);

    // Wrap-around on channel 3
    cyc(1'b1, 2'd3, 8'h30, 4'b0000);
    for (int k = 1; k <= 5; k++) begin
      check("ch3_head", 64'(data_out[31:24]), 64'(8'h30 + k - 1));
      cyc(1'b1, 2'd3, 8'(8'h30 + k), 4'b1000);
    end
    check("ch3_wrap_head", 64'(data_out[31:24]), 64'h35);
    cyc(1'b1, 2'd3, 8'h36, 4'b0000);
    cyc(1'b1, 2'd3, 8'h37, 4'b0000);
    check("ch3_valid", 64'(valid_out), 64'h8);

    // Reset mid-stream with push and pop active
    reset = 1'b0;
    cyc(1'b1, 2'd3, 8'h99, 4'b1111);
    reset = 1'b1;
    check("mid_rst_valid", 64'(valid_out), 64'h0);
    check("mid_rst_data",  64'(data_out),  64'h0);
    check("mid_rst_ovf",   64'(ovf_err),   64'h0);
    check("mid_rst_sel_b", 64'(sel_err_b), 64'h0);

    // Mixed traffic pattern checked by the model every cycle
    for (int k = 0; k < 60; k++) begin
      cyc((k % 3) != 0, 2'(k % 4), 8'(k * 7 + 3), 4'((k * 5) % 16) & 4'((k % 4 == 1) ? 4'b1111 : 4'b0101));
    end
    cyc(1'b0, 2'd0, 8'h00, 4'b0000);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
